// File: rtl/csr_file_pkg.sv
// Shared CPU definitions for the machine-mode CSR block: addresses, bit
// positions, the reset trap vector and the sleep state encoding.
package CPU_def;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  localparam logic [31:0] MTVEC_INIT_DEF = 32'h0001_0000;

  typedef enum logic {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } csr_state_t;

endpackage

// File: rtl/csr_file_if.sv
// Execute-stage to CSR-unit interface: the decoded CSR operation going in,
// the pre-update CSR value coming back.
interface inf_EX_CSR;

  logic [31:0] pc;
  logic [11:0] csr_addr;
  logic [31:0] rs1_rdata;
  logic        reg_wr;
  logic        wr;
  logic        set;
  logic        clr;
  logic        mret;
  logic        wfi;
  logic [31:0] rd_wdata;

  modport EX2CSR (
    output pc, csr_addr, rs1_rdata, reg_wr, wr, set, clr, mret, wfi,
    input  rd_wdata
  );

  modport CSR2EX (
    input  pc, csr_addr, rs1_rdata, reg_wr, wr, set, clr, mret, wfi,
    output rd_wdata
  );

endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable halves; a write to
// either half takes the place of that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) q[31:0]  <= wdata;
      if (wr_hi) q[63:32] <= wdata;
    end else if (inc) begin
      q <= q + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR unit: status/interrupt/trap/counter registers, interrupt
// and mret arbitration, WFI sleep, and a single fetch redirect.
module csr_file
  import CPU_def::*;
#(
  parameter logic [31:0] MTVEC_INIT = MTVEC_INIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  inf_EX_CSR.CSR2EX        ex,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             inst_retire,
  input  logic             irq_ext,
  input  logic             irq_timer,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             csr_stall
);

  csr_state_t  state_q, state_d;
  logic        mstatus_mie, mstatus_mpie;
  logic        mie_mtie, mie_meie;
  logic [31:2] mepc_q;
  logic [31:0] wake_pc_q;
  logic [63:0] mcycle, minstret;

  logic        run, irq_pend, take_irq, commit, csr_op;
  logic        do_mret, do_wfi, wake_trap;
  logic [31:0] old_val, new_val;
  logic        unused_reg_wr;

  assign unused_reg_wr = ex.reg_wr;

  assign run      = (state_q == RUN);
  assign irq_pend = (mie_meie & irq_ext) | (mie_mtie & irq_timer);
  assign take_irq = ex_valid & ~ex_stall & run & mstatus_mie & irq_pend;
  assign commit   = ex_valid & ~ex_stall & ~take_irq & run;
  assign csr_op   = commit & (ex.wr | ex.set | ex.clr);
  assign do_mret  = commit & ex.mret;
  assign do_wfi   = commit & ex.wfi;
  // Waking from WFI ignores MIE; MIE only picks trap versus plain resume.
  assign wake_trap = ~run & irq_pend & mstatus_mie;
  assign csr_stall = ~run;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    old_val = '0;
    unique case (ex.csr_addr)
      CSR_MSTATUS: begin
        old_val[MSTATUS_MIE]  = mstatus_mie;
        old_val[MSTATUS_MPIE] = mstatus_mpie;
        old_val[12:11]        = 2'b11;
      end
      CSR_MIE: begin
        old_val[MIE_MTIE] = mie_mtie;
        old_val[MIE_MEIE] = mie_meie;
      end
      CSR_MIP: begin
        old_val[MIP_MTIP] = irq_timer;
        old_val[MIP_MEIP] = irq_ext;
      end
      CSR_MTVEC:                 old_val = MTVEC_INIT;
      CSR_MEPC:                  old_val = {mepc_q, 2'b00};
      CSR_MCYCLE,   CSR_CYCLE:   old_val = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:  old_val = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET: old_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret[63:32];
      default:                   old_val = '0;
    endcase
  end

  assign ex.rd_wdata = old_val;

  always_comb begin
    new_val = old_val & ~ex.rs1_rdata;
    if (ex.wr)       new_val = ex.rs1_rdata;
    else if (ex.set) new_val = old_val | ex.rs1_rdata;
  end

  always_comb begin
    state_d     = state_q;
    redirect    = 1'b0;
    redirect_pc = '0;
    unique case (state_q)
      RUN: begin
        if (take_irq) begin
          redirect    = 1'b1;
          redirect_pc = MTVEC_INIT;
        end else if (do_mret) begin
          redirect    = 1'b1;
          redirect_pc = {mepc_q, 2'b00};
        end else if (do_wfi) begin
          state_d = SLEEP;
        end
      end
      SLEEP: begin
        if (irq_pend) begin
          redirect    = 1'b1;
          redirect_pc = mstatus_mie ? MTVEC_INIT : wake_pc_q;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mepc_q       <= '0;
      wake_pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (take_irq) begin
        mepc_q       <= ex.pc[31:2];
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (wake_trap) begin
        mepc_q       <= wake_pc_q[31:2];
        mstatus_mpie <= 1'b1;
        mstatus_mie  <= 1'b0;
      end else if (do_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_op) begin
        unique case (ex.csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie  <= new_val[MSTATUS_MIE];
            mstatus_mpie <= new_val[MSTATUS_MPIE];
          end
          CSR_MIE: begin
            mie_mtie <= new_val[MIE_MTIE];
            mie_meie <= new_val[MIE_MEIE];
          end
          CSR_MEPC: mepc_q <= new_val[31:2];
          default: ;
        endcase
      end
      if (do_wfi) wake_pc_q <= ex.pc + 32'd4;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (csr_op && ex.csr_addr == CSR_MCYCLE),
    .wr_hi (csr_op && ex.csr_addr == CSR_MCYCLEH),
    .wdata (new_val),
    .q     (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (inst_retire),
    .wr_lo (csr_op && ex.csr_addr == CSR_MINSTRET),
    .wr_hi (csr_op && ex.csr_addr == CSR_MINSTRETH),
    .wdata (new_val),
    .q     (minstret)
  );

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: a CSR read/write vector table plus
// hand-written interrupt, mret, WFI, stall and reset sequences.
module tb_csr_file;

  typedef enum logic [2:0] {OP_NONE, OP_WR, OP_SET, OP_CLR, OP_MRET, OP_WFI} op_e;

  typedef struct {
    logic        valid;
    op_e         op;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ex_valid, ex_stall, inst_retire, irq_ext, irq_timer;
  logic redirect, csr_stall;
  logic [31:0] redirect_pc;

  inf_EX_CSR ex_if ();

  csr_file dut (
    .clk         (clk),
    .rst         (rst),
    .ex          (ex_if),
    .ex_valid    (ex_valid),
    .ex_stall    (ex_stall),
    .inst_retire (inst_retire),
    .irq_ext     (irq_ext),
    .irq_timer   (irq_timer),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .csr_stall   (csr_stall)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic valid, op_e op, logic [11:0] addr, logic [31:0] rs1,
                       logic [31:0] pc);
    ex_valid        = valid;
    ex_if.pc        = pc;
    ex_if.csr_addr  = addr;
    ex_if.rs1_rdata = rs1;
    ex_if.wr        = (op == OP_WR);
    ex_if.set       = (op == OP_SET);
    ex_if.clr       = (op == OP_CLR);
    ex_if.mret      = (op == OP_MRET);
    ex_if.wfi       = (op == OP_WFI);
    ex_if.reg_wr    = (op == OP_WR) || (op == OP_SET) || (op == OP_CLR);
  endtask

  // Drive one cycle, queue the expected read value, sample at the falling edge.
  task automatic issue(logic valid, op_e op, logic [11:0] addr, logic [31:0] rs1,
                       logic [31:0] pc, logic [31:0] exp_rd, string name);
    exp_t e;
    drive(valid, op, addr, rs1, pc);
    if (name != "") sb.push_back('{name, exp_rd});
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, ex_if.rd_wdata, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read(logic [11:0] addr, logic [31:0] exp_rd, string name);
    issue(1'b0, OP_NONE, addr, 32'h0, 32'h0, exp_rd, name);
    step();
  endtask

  // Sleep sequence: wfi, four quiet sleeping cycles, then the timer wakes us.
  task automatic wfi_sequence(logic [31:0] exp_wake_pc, logic [31:0] exp_mstatus,
                              string tag);
    int stall_cycles;
    stall_cycles = 0;
    issue(1'b1, OP_WFI, 12'h300, 32'h0, 32'h300, exp_mstatus, {tag, "_wfi_rd"});
    check({tag, "_wfi_no_stall_yet"}, {31'h0, csr_stall}, 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, OP_NONE, 12'h0, 32'h0, 32'h0, 32'h0, "");
      if (csr_stall) stall_cycles++;
      check($sformatf("%s_sleep_no_redirect_%0d", tag, i), {31'h0, redirect}, 32'h0);
      step();
    end
    irq_timer = 1'b1;
    issue(1'b0, OP_NONE, 12'h0, 32'h0, 32'h0, 32'h0, "");
    if (csr_stall) stall_cycles++;
    check({tag, "_wake_redirect"}, {31'h0, redirect}, 32'h1);
    check({tag, "_wake_pc"}, redirect_pc, exp_wake_pc);
    check({tag, "_stall_cycles"}, stall_cycles, 32'd5);
    step();
    issue(1'b0, OP_NONE, 12'h0, 32'h0, 32'h0, 32'h0, "");
    check({tag, "_stall_released"}, {31'h0, csr_stall}, 32'h0);
    check({tag, "_redirect_one_cycle"}, {31'h0, redirect}, 32'h0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ex_stall = 1'b0; inst_retire = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0;
    drive(1'b0, OP_NONE, 12'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state; mcycle counts from the first cycle after reset.
    issue(1'b0, OP_NONE, 12'h300, 32'h0, 32'h0, 32'h1800, "rst_mstatus");
    check("rst_redirect", {31'h0, redirect}, 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_csr_stall", {31'h0, csr_stall}, 32'h0);
    step();
    read(12'h304, 32'h0, "rst_mie");
    read(12'h341, 32'h0, "rst_mepc");
    read(12'h305, 32'h0001_0000, "rst_mtvec");
    repeat (6) step();
    issue(1'b1, OP_WR, 12'hB00, 32'hFFFF_FFFF, 32'h0, 32'd10, "mcycle_after_10");
    step();
    read(12'hB00, 32'hFFFF_FFFF, "mcycle_written");
    read(12'hB00, 32'h0, "mcycle_wrapped_lo");
    read(12'hB80, 32'h1, "mcycleh_carry");

    // Table: {valid, op, addr, rs1, expected pre-update read}.
    vecs.push_back('{1'b1, OP_SET, 12'h300, 32'h8,         32'h1800});
    vecs.push_back('{1'b1, OP_CLR, 12'h300, 32'h8,         32'h1808});
    vecs.push_back('{1'b0, OP_NONE, 12'h300, 32'h0,        32'h1800});
    vecs.push_back('{1'b1, OP_WR,  12'h304, 32'h0000_0880, 32'h0});
    vecs.push_back('{1'b0, OP_NONE, 12'h304, 32'h0,        32'h0880});
    vecs.push_back('{1'b1, OP_WR,  12'h341, 32'h0000_1237, 32'h0});
    vecs.push_back('{1'b0, OP_NONE, 12'h341, 32'h0,        32'h1234});
    vecs.push_back('{1'b1, OP_WR,  12'h305, 32'hFFFF_FFFF, 32'h0001_0000});
    vecs.push_back('{1'b0, OP_NONE, 12'h305, 32'h0,        32'h0001_0000});
    vecs.push_back('{1'b1, OP_WR,  12'h123, 32'h5,         32'h0});
    vecs.push_back('{1'b0, OP_NONE, 12'h123, 32'h0,        32'h0});
    vecs.push_back('{1'b1, OP_WR,  12'h344, 32'h0000_FFFF, 32'h0});
    vecs.push_back('{1'b0, OP_NONE, 12'h344, 32'h0,        32'h0});
    vecs.push_back('{1'b1, OP_WR,  12'hB82, 32'h7,         32'h0});
    vecs.push_back('{1'b0, OP_NONE, 12'hC82, 32'h0,        32'h7});
    vecs.push_back('{1'b0, OP_NONE, 12'hC02, 32'h0,        32'h0});
    vecs.push_back('{1'b1, OP_CLR, 12'h304, 32'h0000_0800, 32'h0880});
    vecs.push_back('{1'b0, OP_NONE, 12'h304, 32'h0,        32'h0080});
    vecs.push_back('{1'b1, OP_WR,  12'h341, 32'h0,         32'h1234});
    vecs.push_back('{1'b1, OP_WR,  12'hC80, 32'h55,        32'h1});
    vecs.push_back('{1'b0, OP_NONE, 12'hB80, 32'h0,        32'h1});
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].valid, vecs[i].op, vecs[i].addr, vecs[i].rs1, 32'h0,
            vecs[i].exp_rd, $sformatf("vec%0d_%03h", i, vecs[i].addr));
      step();
    end

    // minstret counts only retiring cycles.
    inst_retire = 1'b1;
    repeat (3) begin
      drive(1'b0, OP_NONE, 12'h0, 32'h0, 32'h0);
      step();
    end
    inst_retire = 1'b0;
    read(12'hB02, 32'h3, "minstret_count");
    read(12'hB82, 32'h7, "minstreth_kept");

    // External interrupt preempts a csrrw; mret returns to the trapped pc.
    issue(1'b1, OP_WR, 12'h304, 32'h0000_0800, 32'h0, 32'h0080, "irq_setup_mie"); step();
    issue(1'b1, OP_SET, 12'h300, 32'h8, 32'h0, 32'h1800, "irq_setup_mstatus"); step();
    irq_ext = 1'b1;
    issue(1'b1, OP_WR, 12'h304, 32'h0, 32'h200, 32'h0800, "irq_csrrw_rd");
    check("irq_redirect", {31'h0, redirect}, 32'h1);
    check("irq_redirect_pc", redirect_pc, 32'h0001_0000);
    step();
    issue(1'b0, OP_NONE, 12'h341, 32'h0, 32'h0, 32'h200, "irq_mepc");
    check("irq_redirect_one_cycle", {31'h0, redirect}, 32'h0);
    step();
    read(12'h344, 32'h0800, "irq_mip");
    read(12'h304, 32'h0800, "irq_csrrw_suppressed");
    read(12'h300, 32'h1880, "irq_mstatus");
    irq_ext = 1'b0;
    issue(1'b1, OP_MRET, 12'h300, 32'h0, 32'h210, 32'h1880, "mret_rd");
    check("mret_redirect", {31'h0, redirect}, 32'h1);
    check("mret_redirect_pc", redirect_pc, 32'h200);
    step();
    read(12'h300, 32'h1888, "mret_mstatus");

    // A CSR op clearing MIE loses to a simultaneous pending interrupt.
    irq_ext = 1'b1;
    issue(1'b1, OP_CLR, 12'h300, 32'h8, 32'h240, 32'h1888, "prio_rd");
    check("prio_redirect", {31'h0, redirect}, 32'h1);
    step();
    irq_ext = 1'b0;
    read(12'h341, 32'h240, "prio_mepc");
    read(12'h300, 32'h1880, "prio_mstatus");

    // WFI with MIE=0 resumes at pc+4 without trapping.
    issue(1'b1, OP_WR, 12'h304, 32'h0000_0080, 32'h0, 32'h0800, "wfi_setup_mie"); step();
    wfi_sequence(32'h304, 32'h1880, "wfi_mie0");
    irq_timer = 1'b0;
    read(12'h341, 32'h240, "wfi_mie0_mepc_kept");
    read(12'h300, 32'h1880, "wfi_mie0_mstatus");

    // WFI with MIE=1 traps to mtvec with mepc at the instruction after wfi.
    issue(1'b1, OP_SET, 12'h300, 32'h8, 32'h0, 32'h1880, "wfi_setup_mstatus"); step();
    wfi_sequence(32'h0001_0000, 32'h1888, "wfi_mie1");
    irq_timer = 1'b0;
    read(12'h341, 32'h304, "wfi_mie1_mepc");
    read(12'h300, 32'h1880, "wfi_mie1_mstatus");

    // Stalled pipeline never takes the interrupt or commits the op.
    issue(1'b1, OP_SET, 12'h300, 32'h8, 32'h0, 32'h1880, "stall_setup"); step();
    irq_timer = 1'b1;
    ex_stall  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, OP_WR, 12'h341, 32'h999, 32'h400, 32'h304, $sformatf("stall_rd_%0d", i));
      check($sformatf("stall_no_redirect_%0d", i), {31'h0, redirect}, 32'h0);
      step();
    end
    irq_timer = 1'b0;
    ex_stall  = 1'b0;
    read(12'h341, 32'h304, "stall_mepc_kept");

    // Reset while sleeping.
    issue(1'b1, OP_WFI, 12'h300, 32'h0, 32'h500, 32'h1888, "rst_sleep_wfi"); step();
    issue(1'b0, OP_NONE, 12'h0, 32'h0, 32'h0, 32'h0, "");
    check("rst_sleep_stalled", {31'h0, csr_stall}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    issue(1'b0, OP_NONE, 12'h300, 32'h0, 32'h0, 32'h1800, "post_rst_mstatus");
    check("post_rst_csr_stall", {31'h0, csr_stall}, 32'h0);
    check("post_rst_redirect", {31'h0, redirect}, 32'h0);
    check("post_rst_redirect_pc", redirect_pc, 32'h0);
    step();
    read(12'h304, 32'h0, "post_rst_mie");
    read(12'h341, 32'h0, "post_rst_mepc");
    read(12'hB82, 32'h0, "post_rst_minstreth");
    read(12'hB00, 32'd4, "post_rst_mcycle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
